lfsr_sched: RTL

Round-robin scheduler that shares one 16-bit Fibonacci LFSR among `NREQ` requesters. Each granted word is produced after the LFSR has advanced `STEPS` times, which decorrelates consecutive consumers. The block sits between the pseudo-random source and the test/traffic engines that consume random words, and it owns seeding of the generator. Polynomial and shift direction match the team's existing 16-bit LFSR: next = {q[14:0], q[15]^q[12]^q[5]^q[0]}.

---
 rtl/lfsr_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/lfsr_sched.sv
// lfsr_sched: round-robin scheduler sharing one 16-bit Fibonacci LFSR among
// NREQ requesters; each delivered word follows STEPS generator advances.
// Optional feature macro: LFSR_SCHED_STATS_EN adds the grant_count output.
module lfsr_sched #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned STEPS      = 4,
  parameter logic [15:0] RESET_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             seed_load,
  input  logic [15:0]      seed,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic             rnd_valid,
  output logic [15:0]      rnd_data,
  output logic             busy
`ifdef LFSR_SCHED_STATS_EN
  ,
  output logic [15:0]      grant_count
`endif
);

  localparam int unsigned LW = 16;
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP  = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  state_t          state;
  logic [LW-1:0]   lfsr;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   winner;
  logic [CW-1:0]   cnt;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [LW-1:0]   seed_fixed;

  // One generator advance: shift left, feedback from taps 15, 12, 5, 0.
  function automatic logic [LW-1:0] lfsr_next(input logic [LW-1:0] q);
    return {q[14:0], q[15] ^ q[12] ^ q[5] ^ q[0]};
  endfunction

  // Requester index base+off, wrapped into 0..NREQ-1.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base,
                                           input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // The all-zero state locks the generator, so a zero seed becomes 1.
  assign seed_fixed = (seed == '0) ? LW'(1) : seed;

  // Round-robin pick: first pending request at or after ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!pick_found && req[rr_idx(ptr, i)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_idx(ptr, i);
      end
    end
  end

  // Scheduler FSM with registered grant, data and busy outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      lfsr      <= RESET_SEED;
      ptr       <= '0;
      winner    <= '0;
      cnt       <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      busy      <= 1'b0;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      if (seed_load) begin
        // Seeding wins everywhere and abandons any transaction in flight.
        lfsr  <= seed_fixed;
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (pick_found) begin
              winner <= pick_idx;
              cnt    <= CW'(STEPS - 1);
              state  <= S_STEP;
              busy   <= 1'b1;
            end
          end
          S_STEP: begin
            lfsr <= lfsr_next(lfsr);
            if (cnt == '0) begin
              state <= S_GRANT;
            end else begin
              cnt <= CW'(cnt - CW'(1));
            end
          end
          S_GRANT: begin
            gnt       <= NREQ'(1) << winner;
            rnd_valid <= 1'b1;
            rnd_data  <= lfsr;
            ptr       <= rr_idx(winner, 1);
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef LFSR_SCHED_STATS_EN
  // Count issued grants; aborted transactions never reach the increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_count <= '0;
    end else if (!seed_load && state == S_GRANT) begin
      grant_count <= 16'(grant_count + 16'd1);
    end
  end
`endif

endmodule
